if_inst_queue: RTL and testbench

IF_INST_QUEUE -- requirements
Module: if_inst_queue

---
 rtl/if_inst_queue.sv | 108 ++++++++++
 tb/tb_if_inst_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_inst_queue.sv
// if_inst_queue: decoupling FIFO that sits between fetch and decode.
// Fetch pushes PC/instruction pairs. Decode receives them through registered
// outputs, which gives a minimum push-to-output latency of two cycles.
// A freeze from decode holds the outputs without blocking pushes.
// A flush (taken branch) empties the queue and the output registers.
// Optional feature: define IFQ_FLUSH_COUNT_EN to add the flush_count output.
// flush_count accumulates, saturating, how many instructions each flush discards.
module if_inst_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_pc,
  input  logic [WIDTH-1:0] push_inst,
  output logic             full,
  input  logic             freeze,
  input  logic             flush,
  output logic             valid_out,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] Instruction_out
`ifdef IFQ_FLUSH_COUNT_EN
  ,
  output logic [15:0]      flush_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_pc   [DEPTH];
  logic [WIDTH-1:0] mem_inst [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  // full comes only from the registered count, so it never reacts to a same-cycle pop
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full && !flush;
  assign pop_ok  = !freeze && !flush && (count != '0);

  // Storage has no reset; the pointers and count alone decide what is readable
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_pc[wr_ptr]   <= push_pc;
      mem_inst[wr_ptr] <= push_inst;
    end
  end

  // Pointers, occupancy and output registers; flush outranks freeze and push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      valid_out       <= 1'b0;
      PC_out          <= '0;
      Instruction_out <= '0;
    end else if (flush) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      valid_out       <= 1'b0;
      PC_out          <= '0;
      Instruction_out <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (!freeze) begin
        if (pop_ok) begin
          valid_out       <= 1'b1;
          PC_out          <= mem_pc[rd_ptr];
          Instruction_out <= mem_inst[rd_ptr];
          rd_ptr          <= rd_ptr + AW'(1);
        end else begin
          valid_out       <= 1'b0;
          PC_out          <= '0;
          Instruction_out <= '0;
        end
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IFQ_FLUSH_COUNT_EN
  logic [16:0] flush_sum;

  assign flush_sum = {1'b0, flush_count} + 17'(count) + 17'(valid_out);

  // Each flush adds the queued entries plus any presented instruction, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_count <= '0;
    end else if (flush) begin
      flush_count <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_inst_queue.sv
// Testbench for if_inst_queue.
// Expected entries go into a scoreboard queue when they are pushed.
// A monitor pops that queue and compares against every newly presented output.
module tb_if_inst_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0;
  logic [31:0] push_pc = '0;
  logic [31:0] push_inst = '0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        full;
  logic        valid_out;
  logic [31:0] PC_out;
  logic [31:0] Instruction_out;
`ifdef IFQ_FLUSH_COUNT_EN
  logic [15:0] flush_count;
`endif

  entry_t      sb[$];
  entry_t      mon_entry;
  logic        popped_edge;
  logic [31:0] last_pc = '0;
  logic [31:0] last_inst = '0;
  int          total = 0;
  int          bad = 0;

  if_inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .push            (push),
    .push_pc         (push_pc),
    .push_inst       (push_inst),
    .full            (full),
    .freeze          (freeze),
    .flush           (flush),
    .valid_out       (valid_out),
    .PC_out          (PC_out),
    .Instruction_out (Instruction_out)
`ifdef IFQ_FLUSH_COUNT_EN
    ,
    .flush_count     (flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, then advance to the next falling edge
  task automatic applyStimulus(input logic p, input logic [31:0] pc, input logic [31:0] inst,
                               input logic frz, input logic fl, input logic expect_accept);
    #1;
    push      = p;
    push_pc   = pc;
    push_inst = inst;
    freeze    = frz;
    flush     = fl;
    if (expect_accept) sb.push_back('{pc: pc, inst: inst});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: an edge without freeze/flush presents a new entry; a frozen edge must hold the old one
  initial begin
    forever begin
      @(posedge clk);
      popped_edge = rst && !freeze && !flush;
      @(negedge clk);
      if (valid_out && popped_edge) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output actual=%h required=none", PC_out);
        end else begin
          mon_entry = sb.pop_front();
          checkOutput("out_pc", PC_out, mon_entry.pc);
          checkOutput("out_inst", Instruction_out, mon_entry.inst);
        end
        last_pc   = PC_out;
        last_inst = Instruction_out;
      end else if (valid_out && rst) begin
        checkOutput("hold_pc", PC_out, last_pc);
        checkOutput("hold_inst", Instruction_out, last_inst);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state, observed before any clock edge
    #3;
    checkOutput("rst_valid", 32'(valid_out), 32'h0);
    checkOutput("rst_pc", PC_out, 32'h0);
    checkOutput("rst_inst", Instruction_out, 32'h0);
    checkOutput("rst_full", 32'(full), 32'h0);
`ifdef IFQ_FLUSH_COUNT_EN
    checkOutput("rst_flush_count", 32'(flush_count), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Single push: two-cycle latency, then a bubble
    applyStimulus(1'b1, 32'h04, 32'hE3A01005, 1'b0, 1'b0, 1'b1);
    checkOutput("lat_no_bypass", 32'(valid_out), 32'h0);
    idle();
    checkOutput("lat_valid", 32'(valid_out), 32'h1);
    idle();
    checkOutput("bubble_valid", 32'(valid_out), 32'h0);
    checkOutput("bubble_pc", PC_out, 32'h0);
    checkOutput("bubble_inst", Instruction_out, 32'h0);

    // Fill while frozen, overflow push ignored, then drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h04 + 32'(4 * i), 32'hA000_0004 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
      checkOutput("fill_full", 32'(full), (i == 3) ? 32'h1 : 32'h0);
    end
    applyStimulus(1'b1, 32'h14, 32'hA000_0014, 1'b1, 1'b0, 1'b0);
    checkOutput("overflow_full", 32'(full), 32'h1);
    checkOutput("overflow_valid", 32'(valid_out), 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle();
      checkOutput("drain_valid", 32'(valid_out), 32'h1);
      checkOutput("drain_full", 32'(full), 32'h0);
    end
    idle();
    checkOutput("drain_bubble", 32'(valid_out), 32'h0);

    // Continuous push and pop: one entry in flight, no gaps, pointers wrap twice
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h04 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
      checkOutput("stream_valid", 32'(valid_out), (i > 0) ? 32'h1 : 32'h0);
      checkOutput("stream_full", 32'(full), 32'h0);
    end
    idle();
    checkOutput("stream_last", 32'(valid_out), 32'h1);
    idle();
    checkOutput("stream_bubble", 32'(valid_out), 32'h0);

    // Freeze holds a presented instruction; release shows the next one
    applyStimulus(1'b1, 32'h20, 32'hC000_0020, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h24, 32'hC000_0024, 1'b0, 1'b0, 1'b1);
    checkOutput("hold_pre_pc", PC_out, 32'h20);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("freeze_pc", PC_out, 32'h20);
      checkOutput("freeze_valid", 32'(valid_out), 32'h1);
    end
    idle();
    checkOutput("unfreeze_pc", PC_out, 32'h24);
    idle();
    checkOutput("unfreeze_bubble", 32'(valid_out), 32'h0);

    // Flush with three queued, one presented, plus a same-cycle push and freeze
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h40 + 32'(4 * i), 32'hD000_0040 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
    end
    idle();
    checkOutput("pre_flush_valid", 32'(valid_out), 32'h1);
    checkOutput("pre_flush_full", 32'(full), 32'h0);
    applyStimulus(1'b1, 32'h99, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    sb.delete();
    checkOutput("flush_valid", 32'(valid_out), 32'h0);
    checkOutput("flush_pc", PC_out, 32'h0);
    checkOutput("flush_inst", Instruction_out, 32'h0);
    checkOutput("flush_full", 32'(full), 32'h0);
`ifdef IFQ_FLUSH_COUNT_EN
    checkOutput("flush_count", 32'(flush_count), 32'h4);
`endif
    for (int i = 0; i < 2; i++) begin
      idle();
      checkOutput("post_flush_valid", 32'(valid_out), 32'h0);
    end
    applyStimulus(1'b1, 32'h50, 32'hE000_0050, 1'b0, 1'b0, 1'b1);
    checkOutput("post_flush_latency", 32'(valid_out), 32'h0);
    idle();
    checkOutput("post_flush_first", PC_out, 32'h50);
    idle();

    // Asynchronous reset between edges with entries queued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h60 + 32'(4 * i), 32'hF000_0060 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
    end
    idle();
    checkOutput("pre_rst_valid", 32'(valid_out), 32'h1);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(valid_out), 32'h0);
    checkOutput("mid_rst_pc", PC_out, 32'h0);
    checkOutput("mid_rst_inst", Instruction_out, 32'h0);
    checkOutput("mid_rst_full", 32'(full), 32'h0);
    sb.delete();
    #1 rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 32'h70, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_after_latency", 32'(valid_out), 32'h0);
    idle();
    checkOutput("rst_after_valid", 32'(valid_out), 32'h1);
    idle();
    checkOutput("rst_after_bubble", 32'(valid_out), 32'h0);

    checkOutput("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
